display_hdmi_rgb_timing_gen: RTL
================================

Name: display_hdmi_rgb_timing_gen

Overview:
Video timing generator and test-pattern source for the HDMI display path. It produces the 24-bit RGB pixel stream, data-valid, and HS/VS syncs consumed directly by the RGB-to-YUV stage, one pixel per iHdmiClk. It provides bring-up patterns (colour bars, ramp, solid, checker) and frame bookkeeping without needing the DDR frame-buffer path.

Parameters:
H_ACTIVE, 1920, active pixels per line
H_FP, 88, horizontal front porch (clocks)
H_SYNC, 44, HS pulse width (clocks)
H_BP, 148, horizontal back porch (clocks)
V_ACTIVE, 1080, active lines per frame
V_FP, 4, vertical front porch (lines)
V_SYNC, 5, VS pulse width (lines)
V_BP, 36, vertical back porch (lines)
HS_POL, 1, asserted level of oRgbHs
VS_POL, 1, asserted level of oRgbVs

Ports:
iHdmiClk  in  1  pixel clock
iRst_n  in  1  reset; synchronous, active-low; clock iHdmiClk
iEnable  in  1  run request
iv2PatternSel  in  2  0 = colour bars, 1 = ramp, 2 = solid, 3 = checker
iv24SolidRgb  in  24  solid colour {R,G,B} for pattern 2
ov8Red / ov8Green / ov8Blue  out  8 each  pixel data
oRgbVd  out  1  active-video valid
oRgbHs  out  1  horizontal sync
oRgbVs  out  1  vertical sync
oFrameStart  out  1  one-cycle pulse coincident with pixel (0,0)
ov16FrameCnt  out  16  frames started since reset; wraps at 0xFFFF->0
oBusy  out  1  state == RUN

Behaviour:
- H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters. Counters: hcnt in 0..H_TOTAL-1, vcnt in 0..V_TOTAL-1. Active region (hcnt < H_ACTIVE) && (vcnt < V_ACTIVE) comes first in line/frame.
- FSM IDLE/RUN:
  - IDLE: hcnt = vcnt = 0; outputs inactive. If iEnable = 1, go to RUN.
  - RUN: hcnt increments. At hcnt = H_TOTAL-1, hcnt wraps and vcnt increments. At the last pixel (H_TOTAL-1, V_TOTAL-1): if iEnable = 0, go to IDLE; otherwise wrap to (0,0).
  - iEnable deasserted mid-frame: the frame always completes.
- Latency: iEnable sampled high in IDLE at cycle N gives RUN with counters (0,0) at N+1. Outputs are registered and lag the counters by 1 clock, so pixel (0,0) appears on the outputs at N+2 with oFrameStart = 1.
- Sync timing (registered, same 1-clock lag):
  - HS asserted for H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, on every line.
  - VS asserted for V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC; whole lines, edges aligned to hcnt = 0.
  - Deasserted level is the complement of *_POL.
- oRgbVd = active region. RGB = 0 whenever oRgbVd = 0.
- iv2PatternSel and iv24SolidRgb are latched at frame start (counters at (0,0)). Changes mid-frame are ignored until the next frame.
- Patterns:
  - Bars: BW = H_ACTIVE/8 (integer division). Bar index increments every BW active pixels and saturates at 7, so the remainder pixels belong to bar 7. Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000. The index resets at hcnt = 0. No divider in the datapath.
  - Ramp: R = G = B = hcnt[7:0].
  - Solid: latched iv24SolidRgb.
  - Checker: FFFFFF if hcnt[5]^vcnt[5] = 0, else 000000.
- ov16FrameCnt increments in the same cycle oFrameStart pulses.
- Reset (any time, including mid-frame): next cycle state IDLE, counters 0, ov16FrameCnt 0, RGB 0, oRgbVd 0, oFrameStart 0, oBusy 0, syncs at deasserted level, latched pattern = 0.

Optional Feature:
DISPLAY_HDMI_TPG_MOTION_EN:
- Defined: ramp value = (hcnt + ov16FrameCnt[7:0])[7:0]. Checker uses (hcnt + ov16FrameCnt[7:0])[5]^vcnt[5]. Result: the pattern scrolls 1 pixel/frame for cable/scaler motion checks.
- Undefined: patterns are static as above. No extra adder logic is generated.

Test Plan:
(Bench params unless stated otherwise: H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3 (H_TOTAL = 24); V_ACTIVE = 4, V_FP = 1, V_SYNC = 2, V_BP = 1 (V_TOTAL = 8).)
1. Reset release, then iEnable = 1 at cycle N -> oFrameStart = 1 and oRgbVd = 1 at N+2. oRgbVd high for 16 clocks per line on lines 0-3 (64 valid per 192-clock frame). HS high at line offsets 18-20. VS high on lines 5-6.
2. Pattern 0 -> per line, pixels 0-1 FFFFFF, 2-3 FFFF00, ..., 14-15 000000. Repeat with H_ACTIVE = 18 -> bar 7 spans pixels 14-17 (4 pixels, black).
3. Pattern 2 with solid 123456; change to ABCDEF mid-frame -> current frame stays 123456, next frame ABCDEF. Change to ramp mid-frame -> applied at next oFrameStart only.
4. iEnable dropped at line 2 -> frame completes all 192 clocks, then oBusy = 0 and outputs idle. Re-raise -> oFrameStart again 2 cycles later; ov16FrameCnt = 2.
5. iRst_n low mid-active-line for 1 cycle -> next cycle oRgbVd = 0, RGB = 0, syncs deasserted, ov16FrameCnt = 0, oBusy = 0.
6. DISPLAY_HDMI_TPG_MOTION_EN defined, ramp pattern -> pixel 0 of frame k reads k[7:0] (frame 3: 03,04,…,12 hex). Macro undefined -> every frame reads 00..0F.

Source files
------------

// File: rtl/display_hdmi_rgb_timing_gen.sv
// HDMI video timing generator and test-pattern source: registered RGB, data-valid, HS/VS.
// Optional `DISPLAY_HDMI_TPG_MOTION_EN scrolls ramp/checker one pixel per frame.
module display_hdmi_rgb_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
) (
  input  logic        iHdmiClk,
  input  logic        iRst_n,
  input  logic        iEnable,
  input  logic [1:0]  iv2PatternSel,
  input  logic [23:0] iv24SolidRgb,
  output logic [7:0]  ov8Red,
  output logic [7:0]  ov8Green,
  output logic [7:0]  ov8Blue,
  output logic        oRgbVd,
  output logic        oRgbHs,
  output logic        oRgbVs,
  output logic        oFrameStart,
  output logic [15:0] ov16FrameCnt,
  output logic        oBusy
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  // Counters are at least 8/6 bits wide so the ramp and checker bit-selects always exist.
  localparam int HW_RAW  = $clog2(H_TOTAL + 1);
  localparam int VW_RAW  = $clog2(V_TOTAL + 1);
  localparam int HW      = (HW_RAW > 8) ? HW_RAW : 8;
  localparam int VW      = (VW_RAW > 6) ? VW_RAW : 6;
  localparam int BW      = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] BAR_LAST = HW'(BW - 1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic          HS_ON    = 1'(HS_POL != 0);
  localparam logic          VS_ON    = 1'(VS_POL != 0);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [HW-1:0] r_bar_cnt;
  logic [2:0]    r_bar_idx;
  logic [1:0]    r_pat_sel;
  logic [23:0]   r_solid;
  logic [23:0]   r_rgb;
  logic          r_vd, r_hs, r_vs, r_fs;
  logic [15:0]   r_frame_cnt;

  logic          w_run, w_origin, w_h_last, w_v_last, w_active, w_hs_on, w_vs_on;
  logic [1:0]    w_pat_sel;
  logic [23:0]   w_solid;
  logic [7:0]    w_h_pat;
  logic [23:0]   w_pixel;

  assign w_run     = (r_state == ST_RUN);
  assign w_origin  = w_run && (r_hcnt == '0) && (r_vcnt == '0);
  assign w_h_last  = (r_hcnt == H_LAST);
  assign w_v_last  = (r_vcnt == V_LAST);
  assign w_active  = w_run && (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
  assign w_hs_on   = w_run && (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
  assign w_vs_on   = w_run && (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
  // Pixel (0,0) already uses the freshly sampled selection, not the previous frame's.
  assign w_pat_sel = w_origin ? iv2PatternSel : r_pat_sel;
  assign w_solid   = w_origin ? iv24SolidRgb  : r_solid;

`ifdef DISPLAY_HDMI_TPG_MOTION_EN
  logic [7:0] w_frame_off;
  // Offset equals the frame count presented alongside this frame's pixels.
  assign w_frame_off = w_origin ? r_frame_cnt[7:0] + 8'd1 : r_frame_cnt[7:0];
  assign w_h_pat     = r_hcnt[7:0] + w_frame_off;
`else
  assign w_h_pat     = r_hcnt[7:0];
`endif

  function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
    case (idx)
      3'd0:    return 24'hFFFFFF;
      3'd1:    return 24'hFFFF00;
      3'd2:    return 24'h00FFFF;
      3'd3:    return 24'h00FF00;
      3'd4:    return 24'hFF00FF;
      3'd5:    return 24'hFF0000;
      3'd6:    return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  always_comb begin
    // NOTE: default assignment first so every path drives w_pixel and no latch is inferred.
    w_pixel = 24'h000000;
    case (w_pat_sel)
      2'd0: w_pixel = bar_rgb(r_bar_idx);
      2'd1: w_pixel = {3{w_h_pat}};
      2'd2: w_pixel = w_solid;
      2'd3: w_pixel = (w_h_pat[5] ^ r_vcnt[5]) ? 24'h000000 : 24'hFFFFFF;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      r_state   <= ST_IDLE;
      r_hcnt    <= '0;
      r_vcnt    <= '0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
      r_pat_sel <= '0;
      r_solid   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hcnt    <= '0;
          r_vcnt    <= '0;
          r_bar_cnt <= '0;
          r_bar_idx <= '0;
          if (iEnable) r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (w_origin) begin
            r_pat_sel <= iv2PatternSel;
            r_solid   <= iv24SolidRgb;
          end
          if (w_h_last) begin
            r_hcnt    <= '0;
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
            if (w_v_last) begin
              r_vcnt <= '0;
              if (!iEnable) r_state <= ST_IDLE;
            end else begin
              r_vcnt <= r_vcnt + V_ONE;
            end
          end else begin
            r_hcnt <= r_hcnt + H_ONE;
            // Bar index steps every BW pixels and parks on bar 7, which absorbs the remainder.
            if (r_bar_idx != 3'd7) begin
              if (r_bar_cnt == BAR_LAST) begin
                r_bar_cnt <= '0;
                r_bar_idx <= r_bar_idx + 3'd1;
              end else begin
                r_bar_cnt <= r_bar_cnt + H_ONE;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge iHdmiClk) begin
    if (!iRst_n) begin
      r_rgb       <= '0;
      r_vd        <= 1'b0;
      r_hs        <= ~HS_ON;
      r_vs        <= ~VS_ON;
      r_fs        <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_rgb <= w_active ? w_pixel : 24'h000000;
      r_vd  <= w_active;
      r_hs  <= w_hs_on ? HS_ON : ~HS_ON;
      r_vs  <= w_vs_on ? VS_ON : ~VS_ON;
      r_fs  <= w_origin;
      if (w_origin) r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  assign {ov8Red, ov8Green, ov8Blue} = r_rgb;
  assign oRgbVd       = r_vd;
  assign oRgbHs       = r_hs;
  assign oRgbVs       = r_vs;
  assign oFrameStart  = r_fs;
  assign ov16FrameCnt = r_frame_cnt;
  assign oBusy        = w_run;

endmodule
